rx_frame_parser: RTL
====================

# rx_frame_parser

Byte-level frame parser sitting directly downstream of the UART receiver. It consumes the receiver's data byte, its one-cycle data-ready strobe and its end-of-packet strobe. It assembles framed command packets of the form SYNC, LEN, LEN payload bytes and an optional CHK byte into an internal payload buffer. For each frame it reports exactly one of two outcomes: success (with the frame length) or an error code.

## Interface
Parameters:
- MAX_LEN, 16: largest legal payload length in bytes; range 1..255.
- SYNC_BYTE, 8'hA5: frame start marker.
- LW, $clog2(MAX_LEN+1): width of `frame_len`; derived.
- AW, $clog2(MAX_LEN) (minimum 1): width of `rd_addr`; derived.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only while `rx_data_ready` is high.
- rx_data_ready  in  1  one-cycle strobe, one strobe per received byte.
- rx_endofpacket  in  1  one-cycle strobe marking a line-idle gap after a burst.
- frame_valid  out  1  one-cycle pulse: a good frame is in the buffer.
- frame_error  out  1  one-cycle pulse: the current frame was dropped.
- error_code  out  2  reason for the drop, valid with `frame_error`: 1 = bad length, 2 = bad checksum, 3 = truncated by end-of-packet.
- frame_len  out  LW  payload length of the last good frame.
- rd_addr  in  AW  payload buffer read index.
- rd_data  out  8  payload byte at `rd_addr`; combinational read.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Reset (asynchronous, active-low):
  - state = IDLE.
  - `frame_valid`, `frame_error`, `error_code`, `frame_len`, byte counter and checksum accumulator all 0.
  - Buffer contents are undefined.
- States: IDLE, LEN, PAYLOAD, CHK. Transitions occur only on cycles where `rx_data_ready`=1, except for the abort rule below.
- IDLE:
  - Byte == SYNC_BYTE -> LEN.
  - Any other byte is silently ignored and produces no error.
- LEN:
  - Byte of 0 or byte > MAX_LEN -> `frame_error` with code 1, then IDLE.
  - Otherwise latch the length, set checksum accumulator = byte, clear the counter, go to PAYLOAD.
- PAYLOAD:
  - Write the byte to buffer[counter], XOR it into the accumulator, increment the counter.
  - On the byte where counter == len-1: go to CHK, or finish the frame directly (see Configuration).
- CHK:
  - Byte == accumulator -> `frame_valid`, `frame_len` <= latched length, then IDLE.
  - Otherwise -> `frame_error` with code 2, then IDLE.
- Abort: `rx_endofpacket`=1 while in LEN, PAYLOAD or CHK -> `frame_error` with code 3, then IDLE.
- Simultaneous `rx_data_ready` and `rx_endofpacket` in the same cycle:
  - The byte is processed.
  - The end-of-packet strobe is ignored for that cycle.
- `rx_endofpacket` in IDLE has no effect.
- SYNC_BYTE arriving inside LEN, PAYLOAD or CHK is treated as data; there is no resynchronisation mid-frame.
- Buffer: MAX_LEN x 8. A good frame's contents stay stable from `frame_valid` until the first payload byte of the next frame is written.
- `frame_len` holds its value until the next `frame_valid`; errors leave it unchanged.
- `error_code` holds its value until the next `frame_error`.
- `rd_addr` >= MAX_LEN returns 8'h00.

## Timing
- Every decision is registered. `frame_valid` and `frame_error` assert in the cycle after the strobe that caused them, high for exactly one cycle.
- `frame_valid` and `frame_error` are never high in the same cycle.
- A new SYNC byte is accepted one cycle after a frame completes or is dropped, i.e. back-to-back strobes are supported.
- `rd_data` follows `rd_addr` combinationally (zero-cycle read). A payload write becomes visible the cycle after its strobe.
- Reset asserted mid-frame: the state returns to IDLE immediately, any pending pulse is cancelled, and no error is reported.

## Configuration
- Macro: RX_FRAME_CHECKSUM_EN.
- Defined:
  - The CHK byte is required, and the CHK state and error code 2 exist.
  - Frame is SYNC, LEN, payload, CHK.
- Undefined:
  - CHK state and accumulator are removed; error code 2 never occurs.
  - `frame_valid` is raised on the cycle after the last payload byte's strobe.
  - Frame is SYNC, LEN, payload.

## Test plan
- RX_FRAME_CHECKSUM_EN defined: bytes A5 02 11 22 31 -> one `frame_valid` pulse, `frame_len`=2, rd_data[0]=11, rd_data[1]=22, `busy` low one cycle later.
- Same frame with CHK=30 -> `frame_error` with `error_code`=2, no `frame_valid`, `frame_len` keeps its previous value.
- Bytes A5 00, and separately A5 11 (17 > MAX_LEN=16) -> each gives `frame_error` with `error_code`=1 and a return to IDLE.
- Bytes A5 03 AA, then an `rx_endofpacket` strobe -> `frame_error` with `error_code`=3. A following A5 01 5A 5B is accepted with `frame_len`=1 and rd_data[0]=5A.
- Leading junk 00 FF, then A5 01 A5 A4 -> the junk is ignored and the in-frame A5 is taken as data: `frame_valid`, rd_data[0]=A5. Also drive `rst_n` low mid-frame -> no pulse, `busy`=0.
- RX_FRAME_CHECKSUM_EN undefined: A5 02 11 22 -> `frame_valid` one cycle after the 22 strobe, `frame_len`=2.

Source files
------------

// File: rtl/rx_frame_parser_if.sv
// Bus between the UART receiver side and rx_frame_parser: the incoming
// byte stream, the frame outcome pulses and the payload read port.
//
// Handshake: rx_data is valid only in cycles where rx_data_ready is high.
// Each such cycle carries exactly one byte and there is no backpressure.
// rx_endofpacket is a one-cycle strobe that is independent of rx_data_ready.
// frame_valid and frame_error are one-cycle pulses and are never high together.
interface rx_frame_parser_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0]    rx_data;
    logic          rx_data_ready;
    logic          rx_endofpacket;
    logic          frame_valid;
    logic          frame_error;
    logic [1:0]    error_code;
    logic [LW-1:0] frame_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic [1:0]    dbg_state;

    // Receiver/consumer side: drives the bytes and the buffer read index.
    modport master (
        output rx_data, rx_data_ready, rx_endofpacket, rd_addr,
        input  frame_valid, frame_error, error_code, frame_len, rd_data, busy, dbg_state
    );

    // Parser side.
    modport slave (
        input  rx_data, rx_data_ready, rx_endofpacket, rd_addr,
        output frame_valid, frame_error, error_code, frame_len, rd_data, busy, dbg_state
    );
endinterface

// File: rtl/rx_frame_parser.sv
// Byte-level frame parser: SYNC, LEN, LEN payload bytes and, when the
// RX_FRAME_CHECKSUM_EN macro is defined, a trailing CHK byte. CHK is the XOR
// of LEN and all payload bytes. Each frame ends in exactly one
// frame_valid or frame_error pulse.
// Error codes: 1 = bad length, 2 = bad checksum, 3 = truncated by end-of-packet.
module rx_frame_parser #(
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    rx_frame_parser_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [LW-1:0] lenReg;
    logic [AW-1:0] count;
    logic [7:0]    buffer [MAX_LEN];
    logic          frameValid;
    logic          frameError;
    logic [1:0]    errorCode;
    logic [LW-1:0] frameLen;
    logic          doValid;
    logic          doError;
    logic [1:0]    doCode;
    logic          lenBad;
    logic          lastByte;
`ifdef RX_FRAME_CHECKSUM_EN
    logic [7:0]    acc;
`endif

    assign lenBad   = (bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B);
    assign lastByte = (LW'(count) == (lenReg - 1'b1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: bytes drive the walk; a bare end-of-packet strobe aborts a frame.
    always_comb begin
        nextState = state;
        if (bus.rx_data_ready) begin
            case (state)
                IDLE:    if (bus.rx_data == SYNC_BYTE) nextState = LEN;
                LEN:     nextState = lenBad ? IDLE : PAYLOAD;
`ifdef RX_FRAME_CHECKSUM_EN
                PAYLOAD: if (lastByte) nextState = CHK;
`else
                PAYLOAD: if (lastByte) nextState = IDLE;
`endif
                default: nextState = IDLE;
            endcase
        end else if (bus.rx_endofpacket && (state != IDLE)) begin
            nextState = IDLE;
        end
    end

    // Frame outcome decisions for this cycle; they are registered into pulses below.
    always_comb begin
        doValid = 1'b0;
        doError = 1'b0;
        doCode  = 2'd0;
        if (bus.rx_data_ready) begin
            case (state)
                LEN: begin
                    if (lenBad) begin
                        doError = 1'b1;
                        doCode  = 2'd1;
                    end
                end
`ifdef RX_FRAME_CHECKSUM_EN
                CHK: begin
                    if (bus.rx_data == acc) begin
                        doValid = 1'b1;
                    end else begin
                        doError = 1'b1;
                        doCode  = 2'd2;
                    end
                end
`else
                PAYLOAD: doValid = lastByte;
`endif
                default: ;
            endcase
        end else if (bus.rx_endofpacket && (state != IDLE)) begin
            doError = 1'b1;
            doCode  = 2'd3;
        end
    end

    // Registered pulses, sticky status and the length/counter/checksum datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameValid <= 1'b0;
            frameError <= 1'b0;
            errorCode  <= 2'd0;
            frameLen   <= '0;
            lenReg     <= '0;
            count      <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
            acc        <= 8'd0;
`endif
        end else begin
            frameValid <= doValid;
            frameError <= doError;
            if (doError) errorCode <= doCode;
            if (doValid) frameLen <= lenReg;
            if (bus.rx_data_ready) begin
                if ((state == LEN) && !lenBad) begin
                    lenReg <= bus.rx_data[LW-1:0];
                    count  <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
                    acc    <= bus.rx_data;
`endif
                end else if (state == PAYLOAD) begin
                    count <= count + 1'b1;
`ifdef RX_FRAME_CHECKSUM_EN
                    acc   <= acc ^ bus.rx_data;
`endif
                end
            end
        end
    end

    // Payload buffer: no reset, written only while collecting payload bytes.
    always_ff @(posedge clk) begin
        if (bus.rx_data_ready && (state == PAYLOAD)) begin
            buffer[count] <= bus.rx_data;
        end
    end

    assign bus.frame_valid = frameValid;
    assign bus.frame_error = frameError;
    assign bus.error_code  = errorCode;
    assign bus.frame_len   = frameLen;
    assign bus.busy        = (state != IDLE);
    assign bus.dbg_state   = state;
    assign bus.rd_data     = (int'(bus.rd_addr) < MAX_LEN) ? buffer[bus.rd_addr] : 8'h00;
endmodule
